// File: rtl/sdr_rd_if.sv
// sdr_rd_if: bundles the read-request, downstream FIFO and SDRAM pin signals of sdr_rd.
//   slave  modport: the sdr_rd controller (takes requests and sdr_DQ, drives the SDRAM pins and FIFO push)
//   master modport: the surrounding logic (requester, FIFO and SDRAM device)
// Signals:
//   sdr_rd_req / sdr_rd_word_cnt[11:0]      one-cycle read request and its word count
//   sdr_bank_addr / row_addr / col_addr     start address (col bits [1:0] ignored)
//   sdr_rdata_free_depth[3:0]               free entries in the downstream FIFO
//   sdr_rdata[15:0] / sdr_rdata_wr          captured word and its FIFO push strobe
//   rd_exit                                 one-cycle pulse when a request has completed
//   sdr_CKE..sdr_nWE, sdr_BA, sdr_A         SDRAM command and address pins
//   sdr_DQ[15:0], sdr_DQM[1:0]              SDRAM data bus (read only) and byte mask
interface sdr_rd_if;
  logic        sdr_rd_req;
  logic [11:0] sdr_rd_word_cnt;
  logic [1:0]  sdr_bank_addr;
  logic [12:0] sdr_row_addr;
  logic [8:0]  sdr_col_addr;
  logic [3:0]  sdr_rdata_free_depth;
  logic [15:0] sdr_rdata;
  logic        sdr_rdata_wr;
  logic        rd_exit;
  logic        sdr_CKE;
  logic        sdr_nCS;
  logic        sdr_nRAS;
  logic        sdr_nCAS;
  logic        sdr_nWE;
  logic [1:0]  sdr_BA;
  logic [12:0] sdr_A;
  logic [15:0] sdr_DQ;
  logic [1:0]  sdr_DQM;

  modport slave (
    input  sdr_rd_req, sdr_rd_word_cnt, sdr_bank_addr, sdr_row_addr, sdr_col_addr,
    input  sdr_rdata_free_depth, sdr_DQ,
    output sdr_rdata, sdr_rdata_wr, rd_exit, sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE,
    output sdr_BA, sdr_A, sdr_DQM
  );

  modport master (
    output sdr_rd_req, sdr_rd_word_cnt, sdr_bank_addr, sdr_row_addr, sdr_col_addr,
    output sdr_rdata_free_depth, sdr_DQ,
    input  sdr_rdata, sdr_rdata_wr, rd_exit, sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE,
    input  sdr_BA, sdr_A, sdr_DQM
  );
endinterface

// File: rtl/sdr_rd.sv
// sdr_rd: SDRAM burst-read controller. Opens a row (ACTIVE), issues BL4 READs paced by
// FIFO room and a 4-cycle command spacing, captures the returning words CL+1 cycles after
// each READ, closes the row (PRECHARGE) at row end or completion, and pulses rd_exit.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sdr_rd_if.slave: request, FIFO push, SDRAM pins (see sdr_rd_if)
module sdr_rd #(
  parameter int unsigned NRCD = 3,  // ACTIVE-to-READ delay, cycles
  parameter int unsigned NRP  = 3,  // PRECHARGE-to-next-command delay, cycles
  parameter int unsigned CL   = 3   // CAS latency, 2..3
) (
  input logic     clk,
  input logic     rst_n,
  sdr_rd_if.slave bus
);

  localparam int unsigned SrW = CL + 4;
  // ACTIVE waits one extra cycle in READ before the first command can issue.
  localparam logic [3:0] RcdLoad = (NRCD >= 2) ? 4'(NRCD - 2) : 4'd0;
  localparam logic [3:0] RpLoad  = (NRP >= 1) ? 4'(NRP - 1) : 4'd0;

  localparam logic [2:0] CmdNop  = 3'b111;
  localparam logic [2:0] CmdAct  = 3'b011;
  localparam logic [2:0] CmdRead = 3'b101;
  localparam logic [2:0] CmdPre  = 3'b010;

  typedef enum logic [1:0] {IDLE, ACTIVE, READ, PRECHARGE} state_t;

  state_t       state_q;
  logic [23:0]  addr_q;      // {bank,row,col} of the next burst to issue
  logic [1:0]   bank_q;      // bank of the currently open row
  logic [11:0]  left_q;      // words still to issue
  logic [11:0]  inflight_q;  // words issued but not yet captured
  logic [3:0]   wait_q;
  logic [1:0]   gap_q;
  logic         row_done_q;
  logic [SrW-1:0] beat_q;    // bit 0 set: capture sdr_DQ on this edge
  logic [2:0]   cmd_q;
  logic [1:0]   ba_q;
  logic [12:0]  a_q;
  logic [15:0]  rdata_q;
  logic         wr_q;
  logic         exit_q;

  logic [2:0]     need;
  logic [3:0]     beat_mask;
  logic           room_ok;
  logic           issue;
  logic           capture;
  logic [11:0]    inflight_next;
  logic [23:0]    addr_inc;
  logic [SrW-1:0] beat_load;

  // Bursts are 4-word aligned, so the low column bits carry no information.
  logic unused_col;
  assign unused_col = ^bus.sdr_col_addr[1:0];

  always_comb begin
    need          = (left_q >= 12'd4) ? 3'd4 : left_q[2:0];
    beat_mask     = 4'hF >> (3'd4 - need);
    room_ok       = ({8'd0, bus.sdr_rdata_free_depth} >= inflight_q + {9'd0, need});
    issue         = (state_q == READ) && (gap_q == 2'd0) && (left_q != 12'd0) &&
                    !row_done_q && room_ok;
    capture       = beat_q[0];
    inflight_next = inflight_q + (issue ? {9'd0, need} : 12'd0) - {11'd0, capture};
    addr_inc      = addr_q + 24'd4;
    // Beat j of a burst lands at position CL+j and reaches bit 0 after CL+j shifts.
    beat_load     = {{CL{1'b0}}, beat_mask} << CL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      bank_q     <= '0;
      left_q     <= '0;
      inflight_q <= '0;
      wait_q     <= '0;
      gap_q      <= '0;
      row_done_q <= 1'b0;
      beat_q     <= '0;
      cmd_q      <= CmdNop;
      ba_q       <= '0;
      a_q        <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
      exit_q     <= 1'b0;
    end else begin
      cmd_q      <= CmdNop;
      wr_q       <= capture;
      exit_q     <= 1'b0;
      if (capture) rdata_q <= bus.sdr_DQ;
      beat_q     <= (beat_q >> 1) | (issue ? beat_load : '0);
      inflight_q <= inflight_next;
      if (gap_q != 2'd0) gap_q <= gap_q - 2'd1;

      unique case (state_q)
        IDLE: begin
          if (bus.sdr_rd_req && (bus.sdr_rd_word_cnt != 12'd0)) begin
            state_q    <= ACTIVE;
            addr_q     <= {bus.sdr_bank_addr, bus.sdr_row_addr, bus.sdr_col_addr[8:2], 2'b00};
            left_q     <= bus.sdr_rd_word_cnt;
            bank_q     <= bus.sdr_bank_addr;
            row_done_q <= 1'b0;
            wait_q     <= RcdLoad;
            cmd_q      <= CmdAct;
            ba_q       <= bus.sdr_bank_addr;
            a_q        <= bus.sdr_row_addr;
          end
        end
        ACTIVE: begin
          if (wait_q == 4'd0) state_q <= READ;
          else                wait_q  <= wait_q - 4'd1;
        end
        READ: begin
          if (issue) begin
            cmd_q  <= CmdRead;
            ba_q   <= bank_q;
            a_q    <= {4'd0, addr_q[8:2], 2'b00};
            addr_q <= addr_inc;
            left_q <= left_q - {9'd0, need};
            gap_q  <= 2'd3;
            // Next burst would wrap the column: this row is finished.
            if (addr_inc[8:0] == 9'd0) row_done_q <= 1'b1;
          end else if (((left_q == 12'd0) || row_done_q) && (inflight_q == 12'd0)) begin
            state_q <= PRECHARGE;
            cmd_q   <= CmdPre;
            ba_q    <= bank_q;
            a_q     <= '0;
            wait_q  <= RpLoad;
          end
        end
        PRECHARGE: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (left_q != 12'd0) begin
            state_q    <= ACTIVE;
            bank_q     <= addr_q[23:22];
            row_done_q <= 1'b0;
            wait_q     <= RcdLoad;
            cmd_q      <= CmdAct;
            ba_q       <= addr_q[23:22];
            a_q        <= addr_q[21:9];
          end else begin
            state_q <= IDLE;
            exit_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sdr_CKE                           = 1'b1;
  assign bus.sdr_nCS                           = 1'b0;
  assign bus.sdr_DQM                           = 2'b00;
  assign {bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE} = cmd_q;
  assign bus.sdr_BA                            = ba_q;
  assign bus.sdr_A                             = a_q;
  assign bus.sdr_rdata                         = rdata_q;
  assign bus.sdr_rdata_wr                      = wr_q;
  assign bus.rd_exit                           = exit_q;

endmodule
